// File: rtl/imem_pkg.sv
// Shared types and sizing for the IMEM write-side loader.
// Used by the byte packer, the loader FSM and its bus interface.
package imem_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int IMEM_ADDR_W    = 9;
    localparam int IMEM_DATA_W    = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input plus IMEM port A write side, bundled for the loader.
// slave = the loader; master = the byte source / IMEM side (or a bench).
interface imem_loader_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);

    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wea,
        output addra,
        output dina
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wea,
        input  addra,
        input  dina
    );

endinterface

// File: rtl/byte_packer.sv
// Shifts accepted bytes into a word, MSB first, and flags the byte that completes it.
// clear has priority over accept so a discarded partial word never leaks into the next one.
module byte_packer
    import imem_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clka,
    input  logic              rsta,
    input  logic              accept,
    input  logic              clear,
    input  logic [7:0]        byte_in,
    output logic [DATA_W-1:0] word,
    output logic              word_full
);

    localparam logic [1:0] IDX_LAST = 2'(BYTES_PER_WORD - 1);

    logic [DATA_W-1:0] word_q, word_d;
    logic [1:0]        idx_q, idx_d;

    always_comb begin
        word_d = word_q;
        idx_d  = idx_q;
        if (clear) begin
            word_d = '0;
            idx_d  = '0;
        end else if (accept) begin
            word_d = {word_q[DATA_W-9:0], byte_in};
            idx_d  = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            word_q <= '0;
            idx_q  <= '0;
        end else begin
            word_q <= word_d;
            idx_q  <= idx_d;
        end
    end

    assign word      = word_q;
    assign word_full = accept && !clear && (idx_q == IDX_LAST);

endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into IMEM as 32-bit words at incrementing addresses.
// state   | meaning
// IDLE    | waiting for start, no bytes accepted
// COLLECT | accepting bytes until a word is complete
// WRITE   | one-cycle IMEM write of the packed word
// DONE    | last word written, done held until restart
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W    = IMEM_ADDR_W,
    parameter int DATA_W    = IMEM_DATA_W,
    parameter int NUM_WORDS = 512
) (
    input  logic               clka,
    input  logic               rsta,
    input  logic               start,
    input  logic               abort,
    imem_loader_if.slave       bus,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W:0]    word_count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              done_q, done_d;
    logic              wea_q, wea_d;
    logic              busy_q, busy_d;
    logic              in_ready_q, in_ready_d;

    logic              accept;
    logic              pack_clear;
    logic              word_full;
    logic [DATA_W-1:0] word;

    // abort suppresses acceptance so a byte arriving with it is simply dropped
    assign accept = bus.in_valid && in_ready_q && !abort;

    byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clka      (clka),
        .rsta      (rsta),
        .accept    (accept),
        .clear     (pack_clear),
        .byte_in   (bus.in_data),
        .word      (word),
        .word_full (word_full)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        count_d    = count_q;
        done_d     = done_q;
        wea_d      = 1'b0;
        pack_clear = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_COLLECT;
                    addr_d     = '0;
                    count_d    = '0;
                    done_d     = 1'b0;
                    pack_clear = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (abort) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b0;
                    pack_clear = 1'b1;
                end else if (word_full) begin
                    state_d = ST_WRITE;
                    wea_d   = 1'b1;
                end
            end
            ST_WRITE: begin
                // the write pulse is already on the port, so it always counts
                count_d = count_q + (ADDR_W+1)'(1);
                if (abort) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b0;
                    pack_clear = 1'b1;
                end else if (addr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_COLLECT;
                    addr_d  = addr_q + ADDR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d     = (state_d == ST_COLLECT) || (state_d == ST_WRITE);
        in_ready_d = (state_d == ST_COLLECT);
    end

    always_ff @(posedge clka) begin
        if (rsta) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            done_q     <= 1'b0;
            wea_q      <= 1'b0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            done_q     <= done_d;
            wea_q      <= wea_d;
            busy_q     <= busy_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.wea      = wea_q;
    assign bus.addra    = addr_q;
    assign bus.dina     = word;
    assign busy         = busy_q;
    assign done         = done_q;
    assign word_count   = count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a 2-word instance for protocol scenarios
// and a 512-word instance for the full-depth load.
module tb_imem_loader;

    logic clk = 1'b0;
    logic rsta;
    logic start2, abort2, start512, abort512;
    logic busy2, done2, busy512, done512;
    logic [9:0] wc2, wc512;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    imem_loader_if #(.ADDR_W(9), .DATA_W(32)) b2 ();
    imem_loader_if #(.ADDR_W(9), .DATA_W(32)) b512 ();

    imem_loader #(.ADDR_W(9), .DATA_W(32), .NUM_WORDS(2)) u2 (
        .clka(clk), .rsta(rsta), .start(start2), .abort(abort2), .bus(b2),
        .busy(busy2), .done(done2), .word_count(wc2)
    );

    imem_loader #(.ADDR_W(9), .DATA_W(32), .NUM_WORDS(512)) u512 (
        .clka(clk), .rsta(rsta), .start(start512), .abort(abort512), .bus(b512),
        .busy(busy512), .done(done512), .word_count(wc512)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] bytes_a [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    int         bub_pat [8] = '{1, 0, 3, 2, 0, 1, 2, 3};
    int         acc_cyc [8];

    logic [8:0]  la [$];
    logic [31:0] ld [$];
    int          lc [$];

    always @(negedge clk) begin
        if (b2.wea === 1'b1) begin
            la.push_back(b2.addra);
            ld.push_back(b2.dina);
            lc.push_back(cyc);
        end
    end

    int          n512 = 0;
    int          seq_err = 0;
    logic [8:0]  last_a;
    logic [31:0] last_d;

    always @(negedge clk) begin
        if (b512.wea === 1'b1) begin
            if (b512.addra !== n512[8:0] || b512.dina !== 32'(n512)) seq_err++;
            last_a = b512.addra;
            last_d = b512.dina;
            n512++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start2();
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
    endtask

    task automatic pulse_abort2();
        abort2 = 1'b1;
        @(posedge clk); #1;
        abort2 = 1'b0;
    endtask

    task automatic send2(input logic [7:0] b, input int bub, output int acc);
        bit ok = 0;
        acc = -1;
        b2.in_valid = 1'b0;
        repeat (bub) begin @(posedge clk); #1; end
        b2.in_valid = 1'b1;
        b2.in_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (b2.in_ready === 1'b1) ok = 1;
            @(posedge clk); #1;
        end
        b2.in_valid = 1'b0;
        if (ok) acc = cyc;
        else begin
            tests++; fails++;
            $display("FAIL send2_timeout byte %h never accepted", b);
        end
    endtask

    task automatic load_bytes2(input int first, input int last, input bit use_bub);
        for (int i = first; i <= last; i++)
            send2(bytes_a[i], use_bub ? bub_pat[i] : 0, acc_cyc[i]);
    endtask

    task automatic send512(input logic [7:0] b);
        bit ok = 0;
        b512.in_valid = 1'b1;
        b512.in_data  = b;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (b512.in_ready === 1'b1) ok = 1;
            @(posedge clk); #1;
        end
        b512.in_valid = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send512_timeout byte %h never accepted", b);
        end
    endtask

    task automatic check_two_writes(input string tag, input bit chk_lat);
        tests++;
        if (la.size() !== 2) begin
            fails++;
            $display("FAIL %s_nwrites got %0d want 2", tag, la.size());
        end else begin
            tests++;
            if (la[0] !== 9'd0 || ld[0] !== 32'h12345678) begin
                fails++;
                $display("FAIL %s_word0 got addr=%0d data=%h want addr=0 data=12345678", tag, la[0], ld[0]);
            end
            tests++;
            if (la[1] !== 9'd1 || ld[1] !== 32'h9ABCDEF0) begin
                fails++;
                $display("FAIL %s_word1 got addr=%0d data=%h want addr=1 data=9abcdef0", tag, la[1], ld[1]);
            end
            if (chk_lat) begin
                tests++;
                if (lc[0] !== acc_cyc[3] || lc[1] !== acc_cyc[7]) begin
                    fails++;
                    $display("FAIL %s_latency got wea cyc %0d/%0d want %0d/%0d", tag, lc[0], lc[1], acc_cyc[3], acc_cyc[7]);
                end
            end
        end
        tests++;
        if (done2 !== 1'b1 || wc2 !== 10'd2 || busy2 !== 1'b0 || b2.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL %s_final got done=%b wc=%0d busy=%b rdy=%b want 1 2 0 0", tag, done2, wc2, busy2, b2.in_ready);
        end
    endtask

    task automatic test_reset();
        tests++;
        if (b2.in_ready !== 1'b0 || b2.wea !== 1'b0 || b2.addra !== 9'd0 || b2.dina !== 32'd0 ||
            busy2 !== 1'b0 || done2 !== 1'b0 || wc2 !== 10'd0) begin
            fails++;
            $display("FAIL reset_state got rdy=%b wea=%b addr=%0d dina=%h busy=%b done=%b wc=%0d want all 0",
                     b2.in_ready, b2.wea, b2.addra, b2.dina, busy2, done2, wc2);
        end
    endtask

    task automatic test_basic();
        la.delete(); ld.delete(); lc.delete();
        pulse_start2();
        load_bytes2(0, 7, 1'b0);
        idle(3);
        check_two_writes("basic", 1'b1);
        pulse_abort2();
        idle(2);
        tests++;
        if (done2 !== 1'b1 || wc2 !== 10'd2) begin
            fails++;
            $display("FAIL abort_in_done got done=%b wc=%0d want 1 2", done2, wc2);
        end
    endtask

    task automatic test_bubbles();
        la.delete(); ld.delete(); lc.delete();
        pulse_start2();
        load_bytes2(0, 7, 1'b1);
        idle(3);
        check_two_writes("bubbles", 1'b1);
    endtask

    task automatic test_start_ignored();
        la.delete(); ld.delete(); lc.delete();
        pulse_start2();
        load_bytes2(0, 1, 1'b0);
        pulse_start2();
        load_bytes2(2, 7, 1'b0);
        idle(3);
        check_two_writes("start_busy", 1'b0);
    endtask

    task automatic test_abort();
        int dummy;
        la.delete(); ld.delete(); lc.delete();
        pulse_start2();
        load_bytes2(0, 3, 1'b0);
        send2(8'hAA, 0, dummy);
        send2(8'hBB, 0, dummy);
        pulse_abort2();
        idle(3);
        tests++;
        if (la.size() !== 1 || done2 !== 1'b0 || wc2 !== 10'd1 || busy2 !== 1'b0 || b2.in_ready !== 1'b0) begin
            fails++;
            $display("FAIL abort_state got nwr=%0d done=%b wc=%0d busy=%b rdy=%b want 1 0 1 0 0",
                     la.size(), done2, wc2, busy2, b2.in_ready);
        end
        la.delete(); ld.delete(); lc.delete();
        pulse_start2();
        load_bytes2(0, 7, 1'b0);
        idle(3);
        check_two_writes("after_abort", 1'b1);
    endtask

    task automatic test_reset_mid();
        la.delete(); ld.delete(); lc.delete();
        pulse_start2();
        load_bytes2(0, 2, 1'b0);
        rsta = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (b2.in_ready !== 1'b0 || b2.wea !== 1'b0 || b2.addra !== 9'd0 || b2.dina !== 32'd0 ||
            busy2 !== 1'b0 || done2 !== 1'b0 || wc2 !== 10'd0) begin
            fails++;
            $display("FAIL midreset_state got rdy=%b wea=%b addr=%0d dina=%h busy=%b done=%b wc=%0d want all 0",
                     b2.in_ready, b2.wea, b2.addra, b2.dina, busy2, done2, wc2);
        end
        rsta = 1'b0;
        idle(3);
        tests++;
        if (la.size() !== 0) begin
            fails++;
            $display("FAIL midreset_nowrite got %0d writes want 0", la.size());
        end
        pulse_start2();
        load_bytes2(0, 7, 1'b0);
        idle(3);
        check_two_writes("post_reset", 1'b1);
    endtask

    task automatic test_full_depth();
        logic [15:0] n;
        start512 = 1'b1;
        @(posedge clk); #1;
        start512 = 1'b0;
        for (int w = 0; w < 512; w++) begin
            n = 16'(w);
            send512(8'h00);
            send512(8'h00);
            send512(n[15:8]);
            send512(n[7:0]);
        end
        idle(3);
        tests++;
        if (n512 !== 512 || seq_err !== 0) begin
            fails++;
            $display("FAIL full_writes got n=%0d seq_err=%0d want 512 0", n512, seq_err);
        end
        tests++;
        if (last_a !== 9'd511 || last_d !== 32'd511) begin
            fails++;
            $display("FAIL full_last got addr=%0d data=%0d want 511 511", last_a, last_d);
        end
        tests++;
        if (wc512 !== 10'd512 || done512 !== 1'b1 || busy512 !== 1'b0) begin
            fails++;
            $display("FAIL full_final got wc=%0d done=%b busy=%b want 512 1 0", wc512, done512, busy512);
        end
        b512.in_valid = 1'b1;
        b512.in_data  = 8'h55;
        idle(3);
        b512.in_valid = 1'b0;
        tests++;
        if (b512.in_ready !== 1'b0 || n512 !== 512 || b512.addra !== 9'd511) begin
            fails++;
            $display("FAIL full_nowrap got rdy=%b n=%0d addr=%0d want 0 512 511", b512.in_ready, n512, b512.addra);
        end
    endtask

    initial begin
        rsta = 1'b1;
        start2 = 1'b0; abort2 = 1'b0; start512 = 1'b0; abort512 = 1'b0;
        b2.in_valid = 1'b0;   b2.in_data = 8'h00;
        b512.in_valid = 1'b0; b512.in_data = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rsta = 1'b0;
        idle(1);

        test_reset();
        test_basic();
        test_bubbles();
        test_start_ignored();
        test_abort();
        test_reset_mid();
        test_full_depth();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
